// File: rtl/ncl_pkg.sv
// Shared NCL boundary definitions: dual-rail encoding, boundary FSM states and the
// binary-to-dual-rail encoder used by the clocked transmitter and receiver.
package ncl_pkg;

  // Widest logical word any boundary block encodes; blocks size the result down.
  localparam int MAX_WIDTH = 64;

  // Rail offsets within the two-wire group of logical bit i (wires 2i and 2i+1).
  localparam int RAIL0 = 0;
  localparam int RAIL1 = 1;

  localparam logic [2*MAX_WIDTH-1:0] DR_NULL = '0;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    IDLE   = 2'd1,
    DATA_W = 2'd2,
    NULL_W = 2'd3
  } ncl_state_e;

  // DATA wavefront for a binary word: exactly one rail of every bit is high.
  function automatic logic [2*MAX_WIDTH-1:0] dr_encode(input logic [MAX_WIDTH-1:0] word);
    logic [2*MAX_WIDTH-1:0] dr;
    dr = DR_NULL;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      dr[2*i+RAIL1] = word[i];
      dr[2*i+RAIL0] = ~word[i];
    end
    return dr;
  endfunction

endpackage

// File: rtl/ncl_sync.sv
// Multi-flop synchronizer for a level coming from the asynchronous NCL domain.
// The reset value is a port so each boundary block can choose its safe assumption.
module ncl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic init_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      ff <= {STAGES{rst_val}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ncl_dr_tx.sv
// Clocked-to-NCL transmitter: takes binary words on valid/ready and drives them as
// four-phase dual-rail wavefronts, pacing DATA and NULL from the synchronized completion.
module ncl_dr_tx
  import ncl_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] dr_out,
  input  logic               comp_in,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        xfer_count
);

  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC);

  ncl_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] dr_q, dr_d, dr_enc;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic [15:0]        xfer_q, xfer_d;
  logic               comp_s;
  logic               waiting;

  // Reset to 1: until the consumer proves it has returned to NULL, assume it has not.
  ncl_sync #(.STAGES(SYNC_STAGES)) u_comp_sync (
    .clk    (clk),
    .init_n (init_n),
    .rst_val(1'b1),
    .d      (comp_in),
    .q      (comp_s)
  );

  assign dr_enc = (2*WIDTH)'(dr_encode(MAX_WIDTH'(in_data)));

  // NOTE: every variable written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    dr_d    = dr_q;
    xfer_d  = xfer_q;

    unique case (state_q)
      SETTLE: begin
        dr_d = '0;
        if (!comp_s) state_d = IDLE;
      end
      IDLE: begin
        if (in_valid && ready_q) begin
          dr_d    = dr_enc;
          state_d = DATA_W;
        end
      end
      DATA_W: begin
        if (comp_s) begin
          dr_d    = '0;
          state_d = NULL_W;
        end
      end
      NULL_W: begin
        if (!comp_s) begin
          xfer_d  = xfer_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: begin
        dr_d    = '0;
        state_d = SETTLE;
      end
    endcase

    ready_d = (state_d == IDLE) && !comp_s;
    busy_d  = (state_d == DATA_W) || (state_d == NULL_W);

    // Wait timer restarts on every state entry and saturates at the limit.
    waiting = (state_q != IDLE);
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting && (cnt_q != TLIM)) begin
      cnt_d = cnt_q + TW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    err_d = err_q | ((TIMEOUT_CYC != 0) && (cnt_d == TLIM));
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= SETTLE;
      dr_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
    end
  end

  assign in_ready    = ready_q;
  assign dr_out      = dr_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign xfer_count  = xfer_q;

endmodule

// File: tb/tb_ncl_dr_tx.sv
// Directed and scoreboarded bench for ncl_dr_tx with a delayed-echo NCL consumer model.
module tb_ncl_dr_tx;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          init_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] dr_out;
  logic          comp_in;
  logic          busy;
  logic          timeout_err;
  logic [15:0]   xfer_count;

  logic cons_en    = 1'b0;
  logic cons_comp  = 1'b0;
  logic force_comp = 1'b0;
  int   cons_delay = 3;

  int n_vec  = 0;
  int n_fail = 0;
  int bad_seq = 0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] prev_dr = '0;

  assign comp_in = cons_en ? cons_comp : force_comp;

  always #5 clk = ~clk;

  ncl_dr_tx #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .init_n     (init_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dr_out     (dr_out),
    .comp_in    (comp_in),
    .busy       (busy),
    .timeout_err(timeout_err),
    .xfer_count (xfer_count)
  );

  typedef struct {
    logic [7:0]  data;
    logic [15:0] exp_dr;
    bit          hold;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [7:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  // Protocol monitor: DATA words are complete and well-formed, and never replace each other.
  always @(negedge clk) begin
    if (init_n) begin
      if (prev_dr != 16'h0 && dr_out != 16'h0 && dr_out != prev_dr) bad_seq++;
      for (int i = 0; i < 8; i++) begin
        if (dr_out[2*i +: 2] == 2'b11) bad_seq++;
        if (dr_out != 16'h0 && dr_out[2*i +: 2] == 2'b00) bad_seq++;
      end
      if (in_ready && busy) bad_seq++;
    end
    prev_dr = dr_out;
  end

  // Consumer model: raises completion cons_delay cycles after DATA, drops it after NULL.
  initial forever begin
    @(negedge clk);
    if (cons_en) begin
      if (!cons_comp && dr_out != 16'h0) begin
        repeat (cons_delay) @(negedge clk);
        cons_comp = 1'b1;
      end else if (cons_comp && dr_out == 16'h0) begin
        repeat (cons_delay) @(negedge clk);
        cons_comp = 1'b0;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    ok = in_ready;
  endtask

  task automatic wait_null(output bit ok);
    int k = 0;
    while (dr_out != 16'h0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    ok = (dr_out == 16'h0);
  endtask

  task automatic wait_count(input logic [15:0] c);
    int k = 0;
    while (xfer_count != c && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Full DATA+NULL transfer; called and returns on a negative clock edge.
  task automatic send(input string nm, input logic [7:0] d, input logic [15:0] exp_dr,
                      input bit hold_after);
    bit ok;
    in_data  = d;
    in_valid = 1'b1;
    wait_ready(ok);
    check({nm, "_ready"}, 32'(ok), 32'd1);
    @(negedge clk);
    if (!hold_after) in_valid = 1'b0;
    in_data = ~d;
    check({nm, "_data"}, 32'(dr_out), 32'(exp_dr));
    wait_null(ok);
    check({nm, "_null"}, 32'(ok), 32'd1);
    exp_cnt = exp_cnt + 16'd1;
    wait_count(exp_cnt);
    check({nm, "_count"}, 32'(xfer_count), 32'(exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    bit   ok;
    int   n;
    int   hi;
    logic [7:0] d;

    vecs[0] = '{data: 8'hA5, exp_dr: 16'h9966, hold: 1'b0};
    vecs[1] = '{data: 8'h00, exp_dr: 16'h5555, hold: 1'b1};
    vecs[2] = '{data: 8'hFF, exp_dr: 16'hAAAA, hold: 1'b0};
    vecs[3] = '{data: 8'h3C, exp_dr: 16'h5AA5, hold: 1'b0};
    vecs[4] = '{data: 8'h81, exp_dr: 16'h9556, hold: 1'b0};
    vecs[5] = '{data: 8'h12, exp_dr: 16'h5659, hold: 1'b0};

    init_n   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check("rst_dr", 32'(dr_out), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(timeout_err), 32'h0);
    check("rst_count", 32'(xfer_count), 32'h0);

    @(negedge clk);
    init_n = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_ready_latency", 32'(n), 32'd3);

    cons_en    = 1'b1;
    cons_delay = 3;
    for (int i = 0; i < 6; i++) begin
      send($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_dr, vecs[i].hold);
    end

    // Consumer stalls with completion low: the wait timer must fire at exactly 16 cycles.
    cons_en    = 1'b0;
    force_comp = 1'b0;
    in_data    = 8'h12;
    in_valid   = 1'b1;
    wait_ready(ok);
    check("to_ready", 32'(ok), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("to_data", 32'(dr_out), 32'h5659);
    repeat (15) @(negedge clk);
    check("to_err_before", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("to_err_at", 32'(timeout_err), 32'd1);
    repeat (10) @(negedge clk);
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    check("to_data_held", 32'(dr_out), 32'h5659);
    force_comp = 1'b1;
    wait_null(ok);
    check("to_null", 32'(ok), 32'd1);
    force_comp = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    wait_count(exp_cnt);
    check("to_count", 32'(xfer_count), 32'(exp_cnt));
    check("to_err_after", 32'(timeout_err), 32'd1);

    // Reset while DATA is on the bus and the consumer still holds completion high.
    in_data  = 8'h3C;
    in_valid = 1'b1;
    wait_ready(ok);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_data", 32'(dr_out), 32'h5AA5);
    force_comp = 1'b1;
    #2;
    init_n = 1'b0;
    #1;
    check("mid_rst_dr", 32'(dr_out), 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_err", 32'(timeout_err), 32'h0);
    check("mid_rst_count", 32'(xfer_count), 32'h0);
    exp_cnt = '0;
    @(negedge clk);
    init_n = 1'b1;
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (in_ready) hi++;
    end
    check("mid_settle_hold", 32'(hi), 32'd0);
    force_comp = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_ready_latency", 32'(n), 32'd3);

    // Random words with random consumer latency against the scoreboard count.
    cons_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cons_delay = $urandom_range(0, 4);
      d = 8'($urandom);
      send($sformatf("rnd%0d", i), d, enc(d), 1'b0);
    end
    check("rnd_err", 32'(timeout_err), 32'd0);
    check("protocol", 32'(bad_seq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
